// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : handshaked RV32I-style ALU with an iterative shifter
//
// Purpose
//   Executes ADD/SUB/AND/OR/XOR/SLT/SLTU in one cycle. SLL/SRL/SRA with a
//   non-zero shift amount run on a one-bit-per-cycle shifter under FSM
//   control. An optional iterative shift-add multiplier (op 10) is built
//   only when the macro ALU_SEQ_MUL_EN is defined. Without the macro, op 10
//   is treated as illegal.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operation request
//   in_ready   out  request can be accepted this cycle
//   op[3:0]    in   0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 SLL,8 SRL,
//                   9 SRA,10 MUL (ALU_SEQ_MUL_EN only), others illegal
//   a, b       in   operands (shifts use b[SHW-1:0] as the amount)
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   result     out  registered result
//   zero       out  registered (result == 0)
//   illegal    out  registered, op was undefined
//
// Timing
//   Shifts with amount n > 0 produce out_valid n clock edges after the
//   accepting edge. MUL produces out_valid WIDTH edges after that edge.
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  // Counter is one bit wider than the shift amount so it can hold WIDTH.
  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif

  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef ALU_SEQ_MUL_EN
    S_MUL   = 2'd2,
`endif
    S_DONE  = 2'd3
  } state_t;

  // Single-cycle ops; non-single-cycle codes return zero.
  function automatic logic [WIDTH-1:0] alu_basic(input logic [3:0] f_op,
                                                 input logic [WIDTH-1:0] f_a,
                                                 input logic [WIDTH-1:0] f_b);
    logic [WIDTH-1:0] v;
    case (f_op)
      OP_ADD:  v = f_a + f_b;
      OP_SUB:  v = f_a - f_b;
      OP_AND:  v = f_a & f_b;
      OP_OR:   v = f_a | f_b;
      OP_XOR:  v = f_a ^ f_b;
      OP_SLT:  v = {{(WIDTH-1){1'b0}}, ($signed(f_a) < $signed(f_b))};
      OP_SLTU: v = {{(WIDTH-1){1'b0}}, (f_a < f_b)};
      default: v = ZERO_W;
    endcase
    return v;
  endfunction

  // One-position shift step; SRA replicates the sign bit.
  function automatic logic [WIDTH-1:0] shift_one(input logic [3:0]       f_op,
                                                 input logic [WIDTH-1:0] f_v);
    logic [WIDTH-1:0] v;
    case (f_op)
      OP_SLL:  v = {f_v[WIDTH-2:0], 1'b0};
      OP_SRL:  v = {1'b0, f_v[WIDTH-1:1]};
      OP_SRA:  v = {f_v[WIDTH-1], f_v[WIDTH-1:1]};
      default: v = f_v;
    endcase
    return v;
  endfunction

  state_t           r_state;
  logic             r_valid;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_ill;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_sop;

  state_t           w_state_nx;
  logic [WIDTH-1:0] w_res_nx;
  logic             w_zero_nx;
  logic             w_ill_nx;
  logic [WIDTH-1:0] w_acc_nx;
  logic [CW-1:0]    w_cnt_nx;
  logic [3:0]       w_sop_nx;

  logic             w_in_ready;
  logic             w_accept;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_basic;
  logic [WIDTH-1:0] w_shift_step;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] w_mcand_nx;
  logic [WIDTH-1:0] w_mplier_nx;
  logic [WIDTH-1:0] w_mul_sum;

  // Add the current partial product when the multiplier LSB is set.
  assign w_mul_sum = r_acc + (r_mplier[0] ? r_mcand : ZERO_W);
`endif

  // DONE can take a new request in the same cycle its result is consumed.
  assign w_in_ready   = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept     = in_valid & w_in_ready;
  assign w_shamt      = b[SHW-1:0];
  assign w_basic      = alu_basic(op, a, b);
  assign w_shift_step = shift_one(r_sop, r_acc);

  // Next-state and datapath next-value logic; every register holds by default.
  always_comb begin
    w_state_nx = r_state;
    w_res_nx   = r_res;
    w_zero_nx  = r_zero;
    w_ill_nx   = r_ill;
    w_acc_nx   = r_acc;
    w_cnt_nx   = r_cnt;
    w_sop_nx   = r_sop;
`ifdef ALU_SEQ_MUL_EN
    w_mcand_nx  = r_mcand;
    w_mplier_nx = r_mplier;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU: begin
              w_res_nx   = w_basic;
              w_zero_nx  = (w_basic == ZERO_W);
              w_ill_nx   = 1'b0;
              w_state_nx = S_DONE;
            end
            OP_SLL, OP_SRL, OP_SRA: begin
              if (w_shamt == {SHW{1'b0}}) begin
                w_res_nx   = a;
                w_zero_nx  = (a == ZERO_W);
                w_ill_nx   = 1'b0;
                w_state_nx = S_DONE;
              end else begin
                w_acc_nx   = a;
                w_cnt_nx   = {1'b0, w_shamt};
                w_sop_nx   = op;
                w_state_nx = S_SHIFT;
              end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
              w_acc_nx    = ZERO_W;
              w_mcand_nx  = a;
              w_mplier_nx = b;
              w_cnt_nx    = CW'(WIDTH);
              w_state_nx  = S_MUL;
            end
`endif
            default: begin
              w_res_nx   = ZERO_W;
              w_zero_nx  = 1'b1;
              w_ill_nx   = 1'b1;
              w_state_nx = S_DONE;
            end
          endcase
        end else if ((r_state == S_DONE) && out_ready) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = r_state;
        end
      end
      S_SHIFT: begin
        w_acc_nx = w_shift_step;
        w_cnt_nx = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_res_nx   = w_shift_step;
          w_zero_nx  = (w_shift_step == ZERO_W);
          w_ill_nx   = 1'b0;
          w_state_nx = S_DONE;
        end else begin
          w_state_nx = S_SHIFT;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        w_acc_nx    = w_mul_sum;
        w_mcand_nx  = {r_mcand[WIDTH-2:0], 1'b0};
        w_mplier_nx = {1'b0, r_mplier[WIDTH-1:1]};
        w_cnt_nx    = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_res_nx   = w_mul_sum;
          w_zero_nx  = (w_mul_sum == ZERO_W);
          w_ill_nx   = 1'b0;
          w_state_nx = S_DONE;
        end else begin
          w_state_nx = S_MUL;
        end
      end
`endif
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State, result and iteration registers; reset discards any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_res   <= ZERO_W;
      r_zero  <= 1'b0;
      r_ill   <= 1'b0;
      r_acc   <= ZERO_W;
      r_cnt   <= {CW{1'b0}};
      r_sop   <= 4'd0;
`ifdef ALU_SEQ_MUL_EN
      r_mcand  <= ZERO_W;
      r_mplier <= ZERO_W;
`endif
    end else begin
      r_state <= w_state_nx;
      r_valid <= (w_state_nx == S_DONE);
      r_res   <= w_res_nx;
      r_zero  <= w_zero_nx;
      r_ill   <= w_ill_nx;
      r_acc   <= w_acc_nx;
      r_cnt   <= w_cnt_nx;
      r_sop   <= w_sop_nx;
`ifdef ALU_SEQ_MUL_EN
      r_mcand  <= w_mcand_nx;
      r_mplier <= w_mplier_nx;
`endif
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign result    = r_res;
  assign zero      = r_zero;
  assign illegal   = r_ill;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : scoreboard bench for alu_seq (WIDTH = 32)
//
// The driver pushes the hand-computed expected response and the clock edge
// at which out_valid must first appear when a request is accepted. The
// monitor pops an entry each time a new result is presented, compares it,
// and checks that held results stay stable under backpressure.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        z;
    logic        ill;
    longint      t_valid;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one request; entered just after a falling edge, returns just after
  // the falling edge following the accepting rising edge.
  task automatic send(input string nm, input logic [3:0] o, input logic [31:0] va,
                      input logic [31:0] vb, input logic [31:0] er, input logic eill,
                      input int lat, output int waits);
    logic acc;
    int   w;
    exp_t e;
    op = o; a = va; b = vb; in_valid = 1'b1;
    acc = 1'b0; w = 0;
    while (!acc && w < 100) begin
      #1;
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        e.name = nm; e.res = er; e.z = (er == 32'd0); e.ill = eill;
        e.t_valid = $time + 64'(10 * lat);
        sb.push_back(e);
      end else begin
        w++;
      end
      @(negedge clk);
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL %s accept: got no accept, expected accept within 100 cycles", nm);
    end
    in_valid = 1'b0;
    waits = w;
  endtask

  // Monitor: compare each newly presented result against the scoreboard.
  logic pv = 1'b0;
  logic ph = 1'b0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      pv = 1'b0;
      ph = 1'b0;
    end else begin
      if (out_valid) begin
        if (!pv || ph) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_result: got 0x%0h, expected no output", result);
          end else begin
            cur = sb.pop_front();
            check({cur.name, " result"},  64'(result),  64'(cur.res));
            check({cur.name, " zero"},    64'(zero),    64'(cur.z));
            check({cur.name, " illegal"}, 64'(illegal), 64'(cur.ill));
            check({cur.name, " latency_time"}, 64'($time - 7), 64'(cur.t_valid));
          end
        end else begin
          check({cur.name, " held_result"}, 64'(result), 64'(cur.res));
          if (!out_ready) check({cur.name, " in_ready_backpressure"}, 64'(in_ready), 64'd0);
        end
      end
      pv = out_valid;
      ph = out_valid && out_ready;
    end
  end

  initial begin
    int w;
    int g;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 4'd0; a = 32'd0; b = 32'd0;
    @(negedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result",    64'(result),    64'd0);
    check("reset zero",      64'(zero),      64'd0);
    check("reset illegal",   64'(illegal),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Basic single-cycle ops
    send("ADD5_7",  4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 0, w);
    send("SUB7_7",  4'd1, 32'd7, 32'd7, 32'd0,  1'b0, 0, w);
    // Back-to-back, one result per cycle
    send("B2B_ADD", 4'd0, 32'd1, 32'd2, 32'd3, 1'b0, 0, w);
    send("B2B_AND", 4'd2, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 0, w);
    check("b2b AND waits", 64'(w), 64'd0);
    send("B2B_OR",  4'd3, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 0, w);
    check("b2b OR waits", 64'(w), 64'd0);
    send("SLT",  4'd5, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 0, w);
    send("SLTU", 4'd6, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 0, w);
    send("XOR",  4'd4, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0, 0, w);

    // Iterative shifts
    send("SRA4", 4'd9, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 4, w);
    for (int i = 0; i < 4; i++) begin
      #2;
      check("SRA4 in_ready_busy", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    send("SLL_sh0", 4'd7, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 0, w);
    send("SRL31",   4'd8, 32'h80000000, 32'd31, 32'd1, 1'b0, 31, w);
    g = 0;
    while (sb.size() != 0 && g < 100) begin @(negedge clk); g++; end

    // Backpressure: hold the ADD result, then consume it while a new op arrives
    out_ready = 1'b0;
    send("BP_ADD", 4'd0, 32'h10, 32'h20, 32'h30, 1'b0, 0, w);
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    send("BP_SUB", 4'd1, 32'h30, 32'h31, 32'hFFFFFFFF, 1'b0, 0, w);
    check("BP same-cycle accept waits", 64'(w), 64'd0);

    // Illegal ops
    send("OP15", 4'd15, 32'h1234, 32'h5678, 32'd0, 1'b1, 0, w);
`ifdef ALU_SEQ_MUL_EN
    send("MUL123_456", 4'd10, 32'd123, 32'd456, 32'd56088, 1'b0, 32, w);
    send("MUL_wrap",   4'd10, 32'h10000, 32'h10000, 32'd0, 1'b0, 32, w);
`else
    send("OP10_illegal", 4'd10, 32'd123, 32'd456, 32'd0, 1'b1, 0, w);
`endif
    g = 0;
    while (sb.size() != 0 && g < 100) begin @(negedge clk); g++; end

    // Leave a non-zero result, then reset in the middle of a shift
    send("SRL1", 4'd8, 32'd2, 32'd1, 32'd1, 1'b0, 1, w);
    repeat (3) @(negedge clk);
    send("SLL20_abort", 4'd7, 32'd1, 32'd20, 32'h00100000, 1'b0, 20, w);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset result",    64'(result),    64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("after_reset in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    send("ADD_after_reset", 4'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 0, w);

    g = 0;
    while (sb.size() != 0 && g < 200) begin @(negedge clk); g++; end
    @(negedge clk);
    #3;
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle 2-op-select ALU for the RISC-V datapath.
- Widens the operation set to the RV32I ALU ops: add, sub, and, or, xor, slt, sltu, sll, srl, sra.
- Shifts run on an iterative one-bit-per-cycle shifter under FSM control; an iterative multiply is optional.
- Sits between decode/operand-fetch and writeback, with valid/ready on both sides.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL (optional), others illegal
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; for shifts only b[SHW-1:0] is used
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  registered (result == 0)
- illegal  out  1  registered; op was undefined

Behaviour:
- Reset (async, rst_n=0) forces the following, with any in-flight operation discarded:
  - state=IDLE, out_valid=0, result=0, zero=0, illegal=0, internal counters=0.
  - in_ready=1 in the first cycle after release.
- States and handshake:
  - States: IDLE, SHIFT, MUL, DONE.
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - An accept is in_valid & in_ready on a rising edge; a, b and op are captured only on accept.
- Single-cycle ops (ADD..SLTU, illegal, and shifts with shamt=0):
  - On accept, result/zero/illegal are registered and the FSM moves to DONE; latency 1 (out_valid high the cycle after accept).
  - Arithmetic wraps modulo 2^WIDTH, no overflow flag.
  - SLT compares signed; SLTU compares unsigned; both produce 0 or 1, zero-extended.
- Shifts with shamt n>0:
  - On accept, the FSM loads the operand and counter=n and moves to SHIFT.
  - Each cycle shifts one position (SLL fills 0, SRL fills 0, SRA fills the sign bit) and decrements the counter.
  - When counter reaches 0, moves to DONE; out_valid rises exactly n cycles after accept.
  - in_ready=0 throughout SHIFT.
- DONE:
  - out_valid=1; result/zero/illegal held stable while out_ready=0.
  - On out_valid & out_ready: if a simultaneous accept occurs, start the new op (back-to-back, throughput 1/cycle for single-cycle ops); otherwise go to IDLE with out_valid=0.
- Illegal op: result=0, zero=1, illegal=1, latency 1; no other side effects.
- zero and illegal are valid only while out_valid=1; they keep their last values otherwise.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - op 10 = MUL, unsigned shift-add, one partial product per cycle over WIDTH cycles in state MUL.
  - result = low WIDTH bits of a*b; out_valid exactly WIDTH cycles after accept; in_ready=0 during MUL.
- Undefined: op 10 is illegal (result 0, illegal=1, latency 1); no MUL state or multiplier logic is synthesised.

Test Plan:
- ADD a=5 b=7 -> result=12, zero=0, out_valid one cycle after accept; SUB a=7 b=7 -> result=0, zero=1; back-to-back with out_ready=1 gives one result per cycle.
- SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0; XOR a=0xF0F0F0F0 b=0xFFFFFFFF -> 0x0F0F0F0F.
- SRA a=0x80000000 b=4 -> 0xF8000000, out_valid exactly 4 cycles after accept, in_ready=0 in between; SLL b=0x20 (shamt 0) -> result=a, latency 1; SRL a=0x80000000 b=31 -> 1 after 31 cycles.
- Backpressure: hold out_ready=0 for 5 cycles after ADD result -> result stable and in_ready=0; raise out_ready with in_valid=1 -> new op accepted in that same cycle.
- Reset mid-operation: SLL b=20, assert rst_n=0 after 5 cycles -> out_valid=0 and result=0 immediately; after release in_ready=1 and a fresh ADD completes normally.
- op=15 -> illegal=1, result=0; with ALU_SEQ_MUL_EN, MUL 123*456 -> 56088 after 32 cycles and 0x10000*0x10000 -> 0; without the macro op=10 -> illegal=1.
